// File: rtl/psec5_cnt_readout.sv
// psec5_cnt_readout: readout controller for the PSEC5 channel counter serializer.
// Walks byte index 0..6: select, load strobe, then 8 SPI_CLK periods per byte.
// CNT_SER is captured LSB first. The 56-bit word is published only when all
// 7 bytes are in.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start_i, byte index held at 0
// SEL    | byte index driven on select_reg_o, strobes low
// LOAD   | load_cnt_ser_o high for LOAD_CYCLES
// GAP    | load strobe low, bit counter cleared before first SPI_CLK rise
// SCK_HI | spi_clk_o high for CLK_DIV cycles
// SCK_LO | spi_clk_o low for CLK_DIV cycles, samples CNT_SER on last cycle
// DONE   | one-cycle done_o, data outputs loaded from the assembled word
module psec5_cnt_readout #(
    parameter int CLK_DIV     = 2,
    parameter int LOAD_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       cnt_ser_i,
    output logic       spi_clk_o,
    output logic       load_cnt_ser_o,
    output logic [2:0] select_reg_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fmt_err_o,
    output logic [2:0] trig_cnt_o,
    output logic [9:0] ca_o,
    output logic [9:0] cb_o,
    output logic [9:0] cc_o,
    output logic [9:0] cd_o,
    output logic [9:0] ce_o
);

    localparam int TMAX = (CLK_DIV > LOAD_CYCLES) ? CLK_DIV : LOAD_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] T_DIV  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] T_LOAD = TW'(LOAD_CYCLES - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_LOAD, S_GAP, S_SCK_HI, S_SCK_LO, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    byte_q, byte_d;
    logic [55:0]   word_q, word_d;
    logic          sync1_q, sync2_q;

    logic          spi_clk_q, spi_clk_d;
    logic          load_q, load_d;
    logic [2:0]    sel_q, sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fmt_err_q;
    logic [2:0]    trig_q;
    logic [9:0]    ca_q, cb_q, cc_q, cd_q, ce_q;

    // State, timer, deserializer registers and the CNT_SER synchronizer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            byte_q    <= '0;
            word_q    <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            word_q    <= word_d;
            sync1_q   <= cnt_ser_i;
            sync2_q   <= sync1_q;
        end
    end

    // Next state plus timer / bit counter / byte assembly; abort overrides all.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        word_d    = word_q;
        case (state_q)
            S_IDLE: begin
                idx_d = 3'd0;
                if (start_i && !abort_i) state_d = S_SEL;
            end
            S_SEL: begin
                tmr_d   = T_LOAD;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (tmr_q != '0) tmr_d = tmr_q - T_ONE;
                else             state_d = S_GAP;
            end
            S_GAP: begin
                bit_cnt_d = 4'd0;
                byte_d    = 8'd0;
                tmr_d     = T_DIV;
                state_d   = S_SCK_HI;
            end
            S_SCK_HI: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - T_ONE;
                end else begin
                    tmr_d   = T_DIV;
                    state_d = S_SCK_LO;
                end
            end
            S_SCK_LO: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - T_ONE;
                end else begin
                    byte_d[bit_cnt_q[2:0]] = sync2_q;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_d == 4'd8) begin
                        word_d[{idx_q, 3'b000} +: 8] = byte_d;
                        if (idx_q == 3'd6) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = S_SEL;
                        end
                    end else begin
                        tmr_d   = T_DIV;
                        state_d = S_SCK_HI;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i) state_d = S_IDLE;
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        spi_clk_d = (state_d == S_SCK_HI);
        load_d    = (state_d == S_LOAD);
        sel_d     = (state_d == S_IDLE) ? 3'd0 : idx_d;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
    end

    // Output registers; data fields load together only on DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spi_clk_q <= 1'b0;
            load_q    <= 1'b0;
            sel_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fmt_err_q <= 1'b0;
            trig_q    <= 3'd0;
            ca_q      <= '0;
            cb_q      <= '0;
            cc_q      <= '0;
            cd_q      <= '0;
            ce_q      <= '0;
        end else begin
            spi_clk_q <= spi_clk_d;
            load_q    <= load_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (done_d) begin
                fmt_err_q <= |word_d[55:53];
                trig_q    <= word_d[52:50];
                ce_q      <= word_d[49:40];
                cd_q      <= word_d[39:30];
                cc_q      <= word_d[29:20];
                cb_q      <= word_d[19:10];
                ca_q      <= word_d[9:0];
            end
        end
    end

    assign spi_clk_o      = spi_clk_q;
    assign load_cnt_ser_o = load_q;
    assign select_reg_o   = sel_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign fmt_err_o      = fmt_err_q;
    assign trig_cnt_o     = trig_q;
    assign ca_o           = ca_q;
    assign cb_o           = cb_q;
    assign cc_o           = cc_q;
    assign cd_o           = cd_q;
    assign ce_o           = ce_q;

endmodule

// File: tb/tb_psec5_cnt_readout.sv
// tb_psec5_cnt_readout: two instances (default timing, and CLK_DIV=3 /
// LOAD_CYCLES=1), each fed by a channel transmitter model. Expected words are
// queued when START is driven and compared when DONE appears.
module tb_psec5_cnt_readout;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_w   [2];
    logic       start;
    logic       abort;
    logic       ser_w   [2];
    logic       spi_w   [2];
    logic       load_w  [2];
    logic [2:0] sel_w   [2];
    logic       busy_w  [2];
    logic       done_w  [2];
    logic       fmt_w   [2];
    logic [2:0] trig_w  [2];
    logic [9:0] ca_w [2], cb_w [2], cc_w [2], cd_w [2], ce_w [2];

    psec5_cnt_readout dut_a (
        .clk_i(clk), .rst_i(rst_w[0]), .start_i(start), .abort_i(abort),
        .cnt_ser_i(ser_w[0]), .spi_clk_o(spi_w[0]), .load_cnt_ser_o(load_w[0]),
        .select_reg_o(sel_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]),
        .fmt_err_o(fmt_w[0]), .trig_cnt_o(trig_w[0]), .ca_o(ca_w[0]),
        .cb_o(cb_w[0]), .cc_o(cc_w[0]), .cd_o(cd_w[0]), .ce_o(ce_w[0]));

    psec5_cnt_readout #(.CLK_DIV(3), .LOAD_CYCLES(1)) dut_b (
        .clk_i(clk), .rst_i(rst_w[1]), .start_i(start), .abort_i(abort),
        .cnt_ser_i(ser_w[1]), .spi_clk_o(spi_w[1]), .load_cnt_ser_o(load_w[1]),
        .select_reg_o(sel_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]),
        .fmt_err_o(fmt_w[1]), .trig_cnt_o(trig_w[1]), .ca_o(ca_w[1]),
        .cb_o(cb_w[1]), .cc_o(cc_w[1]), .cd_o(cd_w[1]), .ce_o(ce_w[1]));

    typedef struct packed {
        logic       fmt;
        logic [2:0] trig;
        logic [9:0] ce, cd, cc, cb, ca;
    } exp_t;

    exp_t  sb [$];
    exp_t  last_e [2];
    logic [55:0] word_m [2];

    // Transmitter model and monitors, evaluated on the falling edge.
    logic [7:0] tx_r   [2];
    int         ptr    [2]  = '{0, 0};
    logic       load_p [2]  = '{1'b0, 1'b0};
    logic       spi_p  [2]  = '{1'b0, 1'b0};
    logic [2:0] sel_p  [2]  = '{3'd0, 3'd0};
    int         rises  [2]  = '{0, 0};
    int         dones  [2]  = '{0, 0};
    int         viol   [2]  = '{0, 0};
    int         loads  [2]  = '{0, 0};
    logic [2:0] sel_rec [2][16];

    initial begin
        ser_w[0] = 1'b0;
        ser_w[1] = 1'b0;
        tx_r[0]  = 8'h00;
        tx_r[1]  = 8'h00;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (load_w[i] === 1'b1 && load_p[i] !== 1'b1) begin
                tx_r[i] = word_m[i][{sel_w[i], 3'b000} +: 8];
                ptr[i]  = 0;
                sel_rec[i][loads[i] % 16] = sel_w[i];
                loads[i]++;
                if (sel_w[i] !== sel_p[i]) viol[i]++;
            end
            if (spi_w[i] === 1'b1 && spi_p[i] !== 1'b1) begin
                ser_w[i] = tx_r[i][ptr[i][2:0]];
                ptr[i]++;
                rises[i]++;
            end
            if (spi_w[i] === 1'b1 && load_w[i] === 1'b1) viol[i]++;
            if (done_w[i] === 1'b1) dones[i]++;
            load_p[i] = load_w[i];
            spi_p[i]  = spi_w[i];
            sel_p[i]  = sel_w[i];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [60:0] outs(input int b);
        return {spi_w[b], load_w[b], sel_w[b], busy_w[b], done_w[b], fmt_w[b],
                trig_w[b], ce_w[b], cd_w[b], cc_w[b], cb_w[b], ca_w[b]};
    endfunction

    function automatic logic [53:0] dat(input int b);
        return {fmt_w[b], trig_w[b], ce_w[b], cd_w[b], cc_w[b], cb_w[b], ca_w[b]};
    endfunction

    // One complete readout on instance b; extra=1 adds ignored START pulses.
    task automatic xfer(input int b, input logic [9:0] ca, cb, cc, cd, ce,
                        input logic [2:0] trig, hi, input int lat_exp, input bit extra);
        exp_t e, g;
        int t0, r0, l0;
        logic [20:0] sel_seq, sel_exp;
        e.ca = ca; e.cb = cb; e.cc = cc; e.cd = cd; e.ce = ce;
        e.trig = trig;
        e.fmt  = (hi != 3'b000);
        word_m[b] = {hi, trig, ce, cd, cc, cb, ca};
        sb.push_back(e);
        r0 = rises[b];
        l0 = loads[b];
        step();
        start = 1'b1;
        t0 = cyc;
        step();
        start = 1'b0;
        chk("busy_rise", busy_w[b], 1);
        while (done_w[b] !== 1'b1 && (cyc - t0) < lat_exp + 20) begin
            step();
            start = extra && ((cyc - t0) == 10 || (cyc - t0) == 100);
        end
        start = 1'b0;
        chk("done_latency", cyc - t0, lat_exp);
        chk("sb_depth", sb.size(), 1);
        g = sb.pop_front();
        chk("ca",   ca_w[b],   g.ca);
        chk("cb",   cb_w[b],   g.cb);
        chk("cc",   cc_w[b],   g.cc);
        chk("cd",   cd_w[b],   g.cd);
        chk("ce",   ce_w[b],   g.ce);
        chk("trig", trig_w[b], g.trig);
        chk("fmt",  fmt_w[b],  g.fmt);
        step();
        chk("busy_fall", busy_w[b], 0);
        chk("spi_rises", rises[b] - r0, 56);
        chk("load_count", loads[b] - l0, 7);
        for (int k = 0; k < 7; k++) begin
            sel_exp[3*k +: 3] = 3'(k);
            sel_seq[3*k +: 3] = sel_rec[b][(l0 + k) % 16];
        end
        chk("select_seq", sel_seq, sel_exp);
        last_e[b] = g;
    endtask

    initial begin
        int d0;
        int k;
        rst_w[0] = 1'b1;
        rst_w[1] = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        word_m[0] = '0;
        word_m[1] = '0;
        repeat (2) step();
        chk("reset_a", outs(0), 0);
        chk("reset_b", outs(1), 0);
        rst_w[0] = 1'b0;

        // full readout, default timing
        xfer(0, 10'h155, 10'h2AA, 10'h3FF, 10'h001, 10'h200, 3'b101, 3'b000, 253, 1'b0);
        // format error word
        xfer(0, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 3'b111, 3'b110, 253, 1'b0);

        // abort during byte 3 SCK_HI
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!(sel_w[0] === 3'd3 && spi_w[0] === 1'b1) && k < 400) begin
            step();
            k++;
        end
        chk("abort_reach_byte3_hi", {sel_w[0], spi_w[0]}, {3'd3, 1'b1});
        d0 = dones[0];
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_ctl", {spi_w[0], load_w[0], busy_w[0], sel_w[0]}, 0);
        repeat (300) step();
        chk("abort_no_done", dones[0] - d0, 0);
        chk("abort_hold", dat(0), last_e[0]);
        xfer(0, 10'h0F0, 10'h10F, 10'h333, 10'h0CC, 10'h2B4, 3'b010, 3'b000, 253, 1'b0);

        // START pulses during a transfer are not queued
        d0 = dones[0];
        xfer(0, 10'h2A5, 10'h05A, 10'h181, 10'h3C3, 10'h07E, 3'b001, 3'b000, 253, 1'b1);
        repeat (300) step();
        chk("arb_one_done", dones[0] - d0, 1);

        // START with ABORT in IDLE stays IDLE
        d0 = dones[0];
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", {busy_w[0], spi_w[0], load_w[0], sel_w[0]}, 0);
        repeat (20) step();
        chk("start_abort_still_idle", {busy_w[0], dones[0] - d0}, 0);

        // reset after a transfer clears every output
        rst_w[0] = 1'b1;
        repeat (2) step();
        chk("reset_after_xfer_a", outs(0), 0);

        // second instance: CLK_DIV=3, LOAD_CYCLES=1
        rst_w[1] = 1'b0;
        xfer(1, 10'h155, 10'h2AA, 10'h3FF, 10'h001, 10'h200, 3'b101, 3'b000, 358, 1'b0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (sel_w[1] !== 3'd5 && k < 500) begin
            step();
            k++;
        end
        chk("rst_mid_reach_byte5", sel_w[1], 5);
        rst_w[1] = 1'b1;
        step();
        chk("rst_mid_outputs", outs(1), 0);
        rst_w[1] = 1'b0;
        xfer(1, 10'h3A1, 10'h0C7, 10'h25E, 10'h118, 10'h3E0, 3'b110, 3'b000, 358, 1'b0);

        chk("proto_a", viol[0], 0);
        chk("proto_b", viol[1], 0);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: summary not reached, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/psec5_cnt_readout.md
# psec5_cnt_readout

Readout controller for the PSEC5 channel counter serializer. It drives `LOAD_CNT_SER`, `SELECT_REG` and `SPI_CLK` into a channel digital block, deserializes the returned `CNT_SER` bitstream and reassembles the 56-bit counter word: `{3'b0, trigger_cnt, CE, CD, CC, CB, CA}`. It sits on the readout side of the channel and is started once the channel is in its readout state.

## Interface
- `CLK_DIV`, default 2: `SPI_CLK` half-period in `CLK` cycles; legal values ≥2.
- `LOAD_CYCLES`, default 2: `LOAD_CNT_SER` pulse width in `CLK` cycles; legal values ≥1.

- `CLK`  in  1  system clock; the single clock for the block.
- `RST`  in  1  synchronous reset, active-high.
- `START`  in  1  one-cycle request to read out all 7 bytes; accepted only in IDLE.
- `ABORT`  in  1  synchronous abort to IDLE.
- `CNT_SER`  in  1  serial data from the channel; asynchronous to `CLK`; passes through a 2-flop synchronizer.
- `SPI_CLK`  out  1  generated shift clock.
- `LOAD_CNT_SER`  out  1  byte load strobe.
- `SELECT_REG`  out  3  byte index, 0..6.
- `BUSY`  out  1  transfer in progress.
- `DONE`  out  1  one-cycle pulse when a complete word is captured.
- `FMT_ERR`  out  1  bits [55:53] of the last captured word were nonzero.
- `TRIG_CNT`  out  3  captured word bits [52:50].
- `CA`, `CB`, `CC`, `CD`, `CE`  out  10 each  captured word bits [9:0], [19:10], [29:20], [39:30] and [49:40].

## Operation
- Reset value: every output is 0. State returns to IDLE. Byte index and shift register are cleared.
- States: IDLE, SEL, LOAD, GAP, SCK_HI, SCK_LO, DONE.
- **IDLE**
  - `START`=1 with `ABORT`=0 moves to SEL.
  - Byte index is set to 0.
- **SEL** (1 cycle)
  - `SELECT_REG` is set to the byte index.
  - `LOAD_CNT_SER` and `SPI_CLK` are 0.
- **LOAD** (`LOAD_CYCLES` cycles)
  - `LOAD_CNT_SER`=1.
  - `SELECT_REG` holds its value.
- **GAP** (1 cycle)
  - `LOAD_CNT_SER`=0.
  - Bit counter is set to 0.
- **SCK_HI** (`CLK_DIV` cycles): `SPI_CLK`=1.
- **SCK_LO** (`CLK_DIV` cycles)
  - `SPI_CLK`=0.
  - On the last cycle, the synchronized `CNT_SER` is shifted into byte bit [bit counter]. Bits arrive LSB first: bit 0 follows the first `SPI_CLK` rise.
  - Bit counter increments on that cycle.
  - Bit counter <8: go to SCK_HI.
  - Bit counter =8 and byte index <6: write the byte to word[8·idx+7 : 8·idx], increment the index, go to SEL.
  - Bit counter =8 and byte index =6: write the byte, go to DONE.
- **DONE** (1 cycle)
  - `DONE`=1.
  - All data outputs and `FMT_ERR` update from the assembled word.
  - `FMT_ERR` = |word[55:53].
  - Next state is IDLE.
- Data outputs hold their value between DONE events. They are never partially updated.
- `BUSY`=1 in every state except IDLE.
- `ABORT` in any state: next cycle is IDLE.
  - `SPI_CLK`, `LOAD_CNT_SER`, `SELECT_REG` and `BUSY` go to 0.
  - No DONE is produced.
  - Data outputs keep their previous value.
- Priority: `RST` > `ABORT` > `START`.
- `START` while `BUSY`=1 is ignored and not queued.
- Exactly 8 `SPI_CLK` rising edges are generated per byte, 56 per word. `SELECT_REG` sequence is 0,1,…,6. `SELECT_REG`=7 is never issued.

## Timing
- All outputs are registered.
- `BUSY` rises the cycle after `START` is accepted.
- Per byte: 2 + `LOAD_CYCLES` + 16·`CLK_DIV` cycles. Default: 36.
- `DONE` asserts 7·(2 + `LOAD_CYCLES` + 16·`CLK_DIV`) + 1 cycles after the `START` edge. Default: 253.
- `BUSY` falls the cycle after `DONE`. A new `START` can be accepted in that cycle.
- Sample point:
  - The last SCK_LO cycle is 2·`CLK_DIV` cycles after the `SPI_CLK` rise.
  - This covers the 2-cycle synchronizer, hence `CLK_DIV` ≥2.
- `SELECT_REG` is stable for ≥1 cycle before and throughout `LOAD_CNT_SER` high.
- `SPI_CLK` is low whenever `LOAD_CNT_SER`=1.
- `LOAD_CNT_SER` falls ≥1 cycle before the first `SPI_CLK` rise.

## Test plan
- **Reset values:** assert `RST` for 2 cycles, with and without a prior transfer → all outputs 0, `BUSY`=0.
- **Full readout:**
  - Stimulus: bench transmitter model (byte select on load, shift out LSB-first on `SPI_CLK` rise) loaded with CA=0x155, CB=0x2AA, CC=0x3FF, CD=0x001, CE=0x200, trigger_cnt=3'b101; pulse `START`.
  - Required: `DONE` at cycle 253; outputs equal the loaded values; `FMT_ERR`=0; 56 `SPI_CLK` rises; `SELECT_REG` sequence 0..6.
- **Format error:** word with [55:53]=3'b110 and all other fields 0x3FF/3'b111 → `FMT_ERR`=1; all fields still captured correctly.
- **Abort:** `ABORT` during byte 3, SCK_HI → IDLE next cycle; `SPI_CLK`=0, `LOAD_CNT_SER`=0, `BUSY`=0; no `DONE`; outputs hold the values from the previous scenario. A subsequent `START` completes normally.
- **Arbitration:**
  - `START` pulsed at cycles 10 and 100 during a transfer → exactly one `DONE`.
  - `START` and `ABORT` in the same IDLE cycle → remains IDLE.
- **Reset mid-transfer:** `RST` during byte 5, with `CLK_DIV`=3 and `LOAD_CYCLES`=1 → all outputs 0 next cycle. A fresh `START` then yields `DONE` at 7·(2+1+48)+1 = 358 cycles with correct data.
